// File: rtl/user_io_debounce.sv
// rtl/user_io_debounce.sv - synchronizer and counter debounce for 4 pushbuttons and 4 DIP switches
// Channels 3:0 are buttons (press/release pulses), 7:4 are switches (sticky change flag).
module user_io_debounce #(
    parameter int         DB_CYCLES     = 500000,
    parameter int         SYNC_STAGES   = 2,
    parameter int         PB_ACTIVE_LOW = 1,
    parameter logic [3:0] DIPSW_RST     = 4'b0000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] pb_raw,
    input  logic [3:0] dipsw_raw,
    output logic [3:0] pb_level,
    output logic [3:0] dipsw_level,
    output logic [3:0] pb_press,
    output logic [3:0] pb_release,
    output logic       dipsw_changed,
    input  logic       dipsw_changed_clr
);

    localparam int             CNT_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic           PB_REL     = (PB_ACTIVE_LOW != 0);
    localparam logic           PB_PRESSED = ~PB_REL;
    localparam logic [7:0]     RST_LEVEL  = {DIPSW_RST, {4{PB_REL}}};

    logic [7:0]       sync_q [SYNC_STAGES];
    logic [7:0]       sync;
    logic [7:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [7:0]       accept;
    logic [3:0]       press_q, press_d;
    logic [3:0]       release_q, release_d;
    logic             changed_q, changed_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Sync flops reset to the idle level so release of reset never looks like an edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RST_LEVEL;
            end
        end else begin
            sync_q[0] <= {dipsw_raw, pb_raw};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        stable_d = stable_q;
        accept   = 8'h00;
        for (int ch = 0; ch < 8; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (sync[ch] == stable_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                accept[ch]   = 1'b1;
                stable_d[ch] = sync[ch];
                cnt_d[ch]    = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
    end

    always_comb begin
        press_d   = accept[3:0] & (PB_PRESSED ? sync[3:0] : ~sync[3:0]);
        release_d = accept[3:0] & (PB_PRESSED ? ~sync[3:0] : sync[3:0]);
        // A new switch accept beats a simultaneous clear.
        changed_d = (changed_q & ~dipsw_changed_clr) | (|accept[7:4]);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stable_q  <= RST_LEVEL;
            press_q   <= 4'h0;
            release_q <= 4'h0;
            changed_q <= 1'b0;
            for (int ch = 0; ch < 8; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            changed_q <= changed_d;
            for (int ch = 0; ch < 8; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign pb_level      = stable_q[3:0];
    assign dipsw_level   = stable_q[7:4];
    assign pb_press      = press_q;
    assign pb_release    = release_q;
    assign dipsw_changed = changed_q;

endmodule

// File: doc/user_io_debounce.md
# user_io_debounce

Conditions the board's raw pushbutton and DIP-switch pins before they reach the `user_pb_external_connection_export` and `user_dipsw_external_connection_export` PIO inputs of `q_sys`. Each of the 8 channels gets:
- a synchronizer into the system clock domain;
- a per-channel counter debounce filter;
- single-cycle press/release pulses for pushbuttons;
- a sticky change flag for the DIP switches, for firmware polling.

## Interface
Parameters:
- `DB_CYCLES`, 500000 — consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range ≥1.
- `SYNC_STAGES`, 2 — synchronizer flops per channel; legal range ≥2.
- `PB_ACTIVE_LOW`, 1 — 1: a button reads 0 when pressed.
- `DIPSW_RST`, 4'b0000 — reset value of the filtered DIP-switch levels.

Ports:
- `clk_clk`  in  1  — the block's only clock. It is the same clock as `clock_bridge_0_in_clk_clk`.
- `reset_reset`  in  1  — synchronous, active-high reset.
- `pb_raw`  in  4  — pushbutton pins, asynchronous.
- `dipsw_raw`  in  4  — DIP-switch pins, asynchronous.
- `pb_level`  out  4  — debounced button levels in board polarity. Connects directly to `user_pb_external_connection_export`.
- `dipsw_level`  out  4  — debounced switch levels. Connects to `user_dipsw_external_connection_export`.
- `pb_press`  out  4  — 1-cycle pulse per button when its debounced level becomes "pressed".
- `pb_release`  out  4  — 1-cycle pulse per button when its debounced level becomes "released".
- `dipsw_changed`  out  1  — sticky flag; set when any debounced switch level changes.
- `dipsw_changed_clr`  in  1  — clears `dipsw_changed`.

## Operation
- Channels 0–3 are the pushbuttons and channels 4–7 are the DIP switches. All channels are identical apart from their reset values.
- Synchronizer: a `SYNC_STAGES`-deep flop chain. Its output is `sync`.
- Filter state per channel:
  - `stable`: the accepted level, driven on `*_level`.
  - `cnt`: a counter of width `$clog2(DB_CYCLES)`, minimum 1 bit.
- Filter update, each edge:
  - `sync == stable`: `cnt <= 0`.
  - `sync != stable` and `cnt == DB_CYCLES-1`: `stable <= sync`, `cnt <= 0`. This is the "accept" event.
  - `sync != stable` otherwise: `cnt <= cnt+1`.
- Any bounce shorter than `DB_CYCLES` consecutive cycles restarts the count and never reaches `stable`.
- The "pressed" level is `~PB_ACTIVE_LOW`.
- Pulses, registered:
  - `pb_press[i] <= accept[i] & (sync[i] == pressed level)`.
  - `pb_release[i] <= accept[i] & (sync[i] != pressed level)`.
  - In all other cycles both pulses are 0. A press and a release for the same button never assert in the same cycle.
- Sticky flag: `dipsw_changed <= (dipsw_changed & ~dipsw_changed_clr) | (|accept[7:4])`. When a set and a clear occur in the same cycle, the set wins.
- Buttons are independent. Simultaneous accepts on several channels each produce their own pulse in the same cycle.

## Timing
- Reset values, applied on the edge where `reset_reset = 1`:
  - Button synchronizer flops and `stable`: the released level (`PB_ACTIVE_LOW ? 1 : 0`).
  - Switch synchronizer flops and `stable`: `DIPSW_RST`.
  - `cnt`: 0.
  - `pb_press`, `pb_release`, `dipsw_changed`: 0.
- Latency: take edge k as the first edge that samples a new raw level, with the level held afterwards. Then:
  - `stable` and `*_level` change at edge k + `SYNC_STAGES` − 1 + `DB_CYCLES`.
  - The pulse or sticky set is visible after that same edge, i.e. from the same edge as the level.
  - Default total: `DB_CYCLES`+2 edges.
- Pulse width: exactly 1 cycle.
- Minimum spacing between successive accepts on one channel: `DB_CYCLES` cycles.
- Reset mid-count: the count is discarded and the level returns to its reset value. If a raw input is still asserted when reset is released, it is debounced again from zero and then produces a normal accept and pulse.
- `DB_CYCLES = 1`: a level is accepted on the first edge where `sync` differs; there is no filtering beyond the synchronizer.
- No combinational path from any input to any output.

## Test plan
Run the bench with `DB_CYCLES=8`, `SYNC_STAGES=2`, `PB_ACTIVE_LOW=1`.
1. Reset release with `pb_raw=4'hF`, `dipsw_raw=4'h0` held for 50 cycles → `pb_level=4'hF`, `dipsw_level=0`, no pulses, `dipsw_changed=0`.
2. At edge k, `pb_raw[0]` goes 1→0 and is held → `pb_level[0]=0` after edge k+9, `pb_press=4'b0001` for exactly one cycle. Raising it back gives `pb_release=4'b0001` 10 edges later.
3. Bounce: `pb_raw[2]` toggles at 0 for 5 cycles, 1 for 1 cycle, repeated 4 times → `pb_level[2]` stays 1 and no pulses. A final hold of 0 gives a press pulse 10 edges after the last toggle.
4. `dipsw_raw` goes 0→4'b1010 at edge k → `dipsw_level=4'b1010` at edge k+9, `dipsw_changed=1` and stays set. Assert `dipsw_changed_clr` for 1 cycle → flag reads 0 on the next edge.
5. A new switch accept lands in the same cycle as `dipsw_changed_clr=1` → `dipsw_changed` remains 1.
6. `pb_raw[1]=0` for 5 cycles, then `reset_reset` pulsed for 1 cycle with `pb_raw[1]` still 0 → `pb_level[1]=1` after reset. The press pulse appears 10 edges after reset deasserts, not earlier.
